pc_fetch_sequencer: RTL
=======================

// Module: pc_fetch_sequencer
// PURPOSE
//  Owns the fetch PC register and sequences instruction fetch for the 5-stage MIPS pipeline.
//  Arbitrates next-PC among sequential (PC+4), decode-stage redirect (pc_decode from the
//  branch/jump address mux), and exception vector. Redirects are held until the instruction
//  memory handshake allows the address to change. Generates the IF/ID flush.
//  Architecture has no branch delay slot.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch address after reset
//  EXC_VECTOR  32'h8000_0180  exception target (used only with PC_SEQ_EXC_EN)
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous, active-low reset
//  stall       in   1   hazard-unit stall: hold PC, ignore redir_valid
//  imem_ready  in   1   imem accepts pc this cycle
//  redir_valid in   1   decode redirect request (branch taken or jump)
//  redir_pc    in   32  redirect target (pc_decode)
//  exc_valid   in   1   exception request (PC_SEQ_EXC_EN only)
//  exc_pc      in   32  PC of the faulting instruction (PC_SEQ_EXC_EN only)
//  pc          out  32  current fetch address (registered)
//  pc_valid    out  1   fetch request valid
//  pc_plus4    out  32  pc + 4, combinational, modulo 2^32
//  flush_ifid  out  1   squash IF/ID this cycle (combinational)
//  epc         out  32  captured exception PC (PC_SEQ_EXC_EN only)
// BEHAVIOUR
//  Reset (async, any time): pc=RESET_PC, pc_valid=0, flush_ifid=0, epc=0, state=BOOT.
//  Any pending redirect is discarded.
//  FSM: BOOT -> RUN after 1 clk. pc_valid=0 in BOOT, 1 in RUN/PEND.
//  fire = pc_valid & imem_ready. Handshake: pc must not change while pc_valid & !imem_ready.
//  Target low bits: pc loads {tgt[31:2],2'b00}.
//  RUN, priority exc > redir > sequential:
//   - req = exc_valid | (redir_valid & !stall); tgt = EXC_VECTOR if exc_valid, else redir_pc.
//   - req & imem_ready: pc<=tgt at the edge; flush_ifid=1 this cycle; stay RUN.
//   - req & !imem_ready: pend_pc<=tgt; go to PEND; pc unchanged; flush_ifid=0.
//   - no req: fire & !stall -> pc<=pc+4 (0xFFFF_FFFC wraps to 0); otherwise pc held.
//  PEND:
//   - imem_ready=1: pc<=pend_pc; flush_ifid=1; go to RUN. Applies regardless of stall.
//   - exc_valid: pend_pc<=EXC_VECTOR (same cycle applies it if imem_ready=1).
//   - redir_valid: ignored (wrong-path or stalled decode).
//  flush_ifid is never asserted in BOOT. At most one flush pulse per accepted redirect.
//  Same-cycle redir_valid & stall in RUN: redirect dropped; decode must reassert it.
//  Latency: redirect seen in cycle t with imem_ready -> target on pc in cycle t+1.
// CONFIGURATION
//  PC_SEQ_EXC_EN defined:
//   - exc_valid honoured as above.
//   - epc<=exc_pc on every accepted exc_valid (in RUN or PEND).
//  Not defined:
//   - exc_valid and exc_pc ignored; epc tied to 0.
//   - EXC_VECTOR unused; only redir and sequential sources exist.
// TESTING
//  1. rst_n low then release, imem_ready=1 -> pc_valid 0 for 1 clk, then pc
//     0x0,0x4,0x8,... every clk.
//  2. pc=0x10, redir_valid=1, redir_pc=0x40, imem_ready=1 -> flush_ifid=1 that cycle;
//     next pc=0x40, then 0x44.
//  3. pc=0x10, redir to 0x80 with imem_ready=0 for 3 clks -> pc holds 0x10, no flush;
//     on ready: flush=1, next pc=0x80.
//  4. stall=1, redir_valid=1 -> pc held, no flush; RESET_PC=32'hFFFF_FFFC with
//     imem_ready=1 -> pc wraps to 0x0.
//  5. EXC_EN: in PEND (pend 0x80), exc_valid with exc_pc=0x14, then imem_ready
//     -> pc=0x8000_0180, epc=0x14.
//  6. Assert rst_n low while in PEND -> pc=RESET_PC immediately; after release,
//     pending target never appears.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Fetch PC owner for the 5-stage MIPS pipeline: sequential/redirect/exception next-PC
// arbitration with imem handshake hold. Optional exception path: define PC_SEQ_EXC_EN.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic [31:0] pc_plus4,
  output logic        flush_ifid,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_PEND
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic        r_pc_valid;

  logic        w_exc;
  logic [31:0] w_exc_tgt;
  logic        w_req;
  logic [31:0] w_tgt;
  logic [31:0] w_pend_tgt;
  logic [31:0] w_pc_plus4;

`ifdef PC_SEQ_EXC_EN
  assign w_exc     = exc_valid;
  assign w_exc_tgt = {EXC_VECTOR[31:2], 2'b00};
`else
  logic w_unused;
  assign w_exc     = 1'b0;
  assign w_exc_tgt = '0;
  assign w_unused  = ^{exc_valid, exc_pc, EXC_VECTOR};
`endif

  // A stalled decode cannot redirect, but an exception is never blocked by stall.
  assign w_req      = w_exc | (redir_valid & ~stall);
  assign w_tgt      = w_exc ? w_exc_tgt : {redir_pc[31:2], 2'b00};
  assign w_pend_tgt = w_exc ? w_exc_tgt : r_pend_pc;
  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_pend_pc  <= '0;
      r_pc_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state    <= ST_RUN;
          r_pc_valid <= 1'b1;
        end
        ST_RUN: begin
          if (w_req) begin
            if (imem_ready) begin
              r_pc <= w_tgt;
            end else begin
              r_pend_pc <= w_tgt;
              r_state   <= ST_PEND;
            end
          end else if (imem_ready && !stall) begin
            r_pc <= w_pc_plus4;
          end
        end
        ST_PEND: begin
          // Held target is applied as soon as imem lets the address move; stall is irrelevant.
          if (imem_ready) begin
            r_pc    <= w_pend_tgt;
            r_state <= ST_RUN;
          end else begin
            r_pend_pc <= w_pend_tgt;
          end
        end
        default: begin
          r_state    <= ST_BOOT;
          r_pc_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    flush_ifid = 1'b0;
    case (r_state)
      ST_RUN:  flush_ifid = w_req & imem_ready;
      ST_PEND: flush_ifid = imem_ready;
      default: flush_ifid = 1'b0;
    endcase
  end

`ifdef PC_SEQ_EXC_EN
  logic [31:0] r_epc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epc <= '0;
    end else if (w_exc && (r_state == ST_RUN || r_state == ST_PEND)) begin
      r_epc <= exc_pc;
    end
  end

  assign epc = r_epc;
`else
  assign epc = '0;
`endif

  assign pc       = r_pc;
  assign pc_valid = r_pc_valid;
  assign pc_plus4 = w_pc_plus4;

endmodule
